// File: rtl/router_sync_n.sv
// router_sync_n: N-channel header address latch, FIFO write steering and per-channel unread-data timeout
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   din             destination address, latched when detect_addr is high
//   wr_en_reg       write request from the router FSM
//   full, empty     per-FIFO status flags
//   rd_en           per-FIFO read enables from downstream
//   clr_status      per-channel clear for timeout_sticky
//   wr_en           one-hot (or zero) write enable to the addressed FIFO
//   fifo_full       full flag of the addressed FIFO (forced high on a bad address)
//   vld_out         per-channel data valid
//   soft_reset      one-cycle timeout pulse per FIFO
//   addr_err        latched address does not name a channel
//   timeout_sticky  sticky record of soft_reset events
module router_sync_n #(
   parameter int NUM_CH  = 3,
   parameter int ADDR_W  = 2,
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] din,
   input  logic              detect_addr,
   input  logic              wr_en_reg,
   input  logic [NUM_CH-1:0] full,
   input  logic [NUM_CH-1:0] empty,
   input  logic [NUM_CH-1:0] rd_en,
   input  logic [NUM_CH-1:0] clr_status,
   output logic [NUM_CH-1:0] wr_en,
   output logic              fifo_full,
   output logic [NUM_CH-1:0] vld_out,
   output logic [NUM_CH-1:0] soft_reset,
   output logic              addr_err,
   output logic [NUM_CH-1:0] timeout_sticky
);
   logic [ADDR_W-1:0] addr_q;
   logic [NUM_CH-1:0] sel;
   logic [CNT_W-1:0]  cnt [NUM_CH];
   always_comb begin
      sel       = NUM_CH'(1) << addr_q;
      wr_en     = (wr_en_reg && !addr_err) ? sel : '0;
      // a bad address reports full so the FSM stalls instead of writing nowhere
      fifo_full = addr_err | (|(full & sel));
      vld_out   = ~empty;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= '0;
         addr_err <= 1'b0;
      end else if (detect_addr) begin
         addr_q   <= din;
         addr_err <= 32'(din) >= 32'(NUM_CH);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         soft_reset     <= '0;
         timeout_sticky <= '0;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else begin
         // the registered pulse sets the flag, so a clear arriving while the pulse is visible loses
         timeout_sticky <= soft_reset | (timeout_sticky & ~clr_status);
         for (int i = 0; i < NUM_CH; i++) begin
            if (vld_out[i] && !rd_en[i]) begin
               soft_reset[i] <= cnt[i] == CNT_W'(TIMEOUT - 1);
               cnt[i]        <= (cnt[i] == CNT_W'(TIMEOUT - 1)) ? '0 : cnt[i] + 1'b1;
            end else begin
               soft_reset[i] <= 1'b0;
               cnt[i]        <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_router_sync_n.sv
// tb_router_sync_n: randomized and directed check of router_sync_n (3-channel and 5-channel builds) against a run-length reference model
module tb_router_sync_n;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] din [2];
   logic       det [2];
   logic       wreg [2];
   logic [7:0] full [2];
   logic [7:0] empty [2];
   logic [7:0] rd [2];
   logic [7:0] clr [2];
   logic [2:0] we0, vo0, sr0, st0;
   logic [4:0] we1, vo1, sr1, st1;
   logic       ff0, ff1, ae0, ae1;
   int nch [2] = '{3, 5};
   int tmo [2] = '{30, 8};
   int total = 0;
   int bad = 0;
   int m_addr [2];
   logic m_err [2];
   logic [7:0] m_sr [2];
   logic [7:0] m_st [2];
   int m_run [2][8];
   always #5 clk = ~clk;
   router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30), .CNT_W(6)) dut0 (
      .clk(clk), .rst(rst), .din(din[0][1:0]), .detect_addr(det[0]), .wr_en_reg(wreg[0]),
      .full(full[0][2:0]), .empty(empty[0][2:0]), .rd_en(rd[0][2:0]), .clr_status(clr[0][2:0]),
      .wr_en(we0), .fifo_full(ff0), .vld_out(vo0), .soft_reset(sr0), .addr_err(ae0),
      .timeout_sticky(st0));
   router_sync_n #(.NUM_CH(5), .ADDR_W(3), .TIMEOUT(8), .CNT_W(6)) dut1 (
      .clk(clk), .rst(rst), .din(din[1]), .detect_addr(det[1]), .wr_en_reg(wreg[1]),
      .full(full[1][4:0]), .empty(empty[1][4:0]), .rd_en(rd[1][4:0]), .clr_status(clr[1][4:0]),
      .wr_en(we1), .fifo_full(ff1), .vld_out(vo1), .soft_reset(sr1), .addr_err(ae1),
      .timeout_sticky(st1));
   task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask
   task automatic check_all();
      logic [7:0] msk, ew, ev, gw, gv, gs, gt;
      logic eff, gf, ga;
      for (int k = 0; k < 2; k++) begin
         msk = 8'((9'd1 << nch[k]) - 9'd1);
         ew  = (wreg[k] && !m_err[k]) ? 8'(1) << m_addr[k] : 8'h00;
         eff = m_err[k] ? 1'b1 : full[k][m_addr[k]];
         ev  = ~empty[k] & msk;
         gw  = k == 0 ? {5'b0, we0} : {3'b0, we1};
         gv  = k == 0 ? {5'b0, vo0} : {3'b0, vo1};
         gs  = k == 0 ? {5'b0, sr0} : {3'b0, sr1};
         gt  = k == 0 ? {5'b0, st0} : {3'b0, st1};
         gf  = k == 0 ? ff0 : ff1;
         ga  = k == 0 ? ae0 : ae1;
         chk("wr_en", k, 32'(gw), 32'(ew));
         chk("fifo_full", k, 32'(gf), 32'(eff));
         chk("vld_out", k, 32'(gv), 32'(ev));
         chk("soft_reset", k, 32'(gs), 32'(m_sr[k]));
         chk("addr_err", k, 32'(ga), 32'(m_err[k]));
         chk("timeout_sticky", k, 32'(gt), 32'(m_st[k]));
      end
   endtask
   task automatic upd();
      logic [7:0] old;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_addr[k] = 0;
            m_err[k]  = 1'b0;
            m_sr[k]   = 8'h00;
            m_st[k]   = 8'h00;
            for (int i = 0; i < 8; i++) m_run[k][i] = 0;
         end else begin
            old = m_sr[k];
            if (det[k]) begin
               m_addr[k] = int'(din[k]);
               m_err[k]  = m_addr[k] >= nch[k];
            end
            for (int i = 0; i < nch[k]; i++) begin
               if (!empty[k][i] && !rd[k][i]) begin
                  m_run[k][i]++;
                  m_sr[k][i] = (m_run[k][i] % tmo[k]) == 0;
               end else begin
                  m_run[k][i] = 0;
                  m_sr[k][i]  = 1'b0;
               end
            end
            m_st[k] = (old | (m_st[k] & ~clr[k])) & 8'((9'd1 << nch[k]) - 9'd1);
         end
      end
   endtask
   task automatic tick();
      #1 check_all();
      @(posedge clk);
      upd();
      @(negedge clk);
   endtask
   task automatic idle();
      for (int k = 0; k < 2; k++) begin
         din[k]  = 3'd0;
         det[k]  = 1'b0;
         wreg[k] = 1'b0;
         full[k] = 8'h00;
         empty[k] = 8'hFF;
         rd[k]   = 8'h00;
         clr[k]  = 8'h00;
      end
   endtask
   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask
   task automatic rnd();
      for (int k = 0; k < 2; k++) begin
         det[k]  = $urandom_range(0, 9) == 0;
         din[k]  = 3'($urandom_range(0, k == 0 ? 3 : 7));
         wreg[k] = 1'($urandom_range(0, 1));
         full[k] = 8'($urandom);
         for (int i = 0; i < 8; i++) begin
            empty[k][i] = $urandom_range(0, 59) == 0;
            rd[k][i]    = $urandom_range(0, 49) == 0;
            clr[k][i]   = $urandom_range(0, 19) == 0;
         end
      end
      rst = $urandom_range(0, 499) == 0;
   endtask
   initial begin
      int pulses;
      logic found;
      idle();
      @(negedge clk);
      do_reset();
      tick();
      full[0] = 8'h01;
      wreg[0] = 1'b1;
      #1;
      chk("rst_wr_en", 0, 32'(we0), 32'h1);
      chk("rst_fifo_full", 0, 32'(ff0), 32'h1);
      chk("rst_sticky", 0, 32'(st0), 32'h0);
      idle();
      det[0] = 1'b1; din[0] = 3'd2;
      tick();
      det[0] = 1'b0; wreg[0] = 1'b1; full[0] = 8'h04;
      #1;
      chk("steer_wr_en", 0, 32'(we0), 32'h4);
      chk("steer_full", 0, 32'(ff0), 32'h1);
      tick();
      det[0] = 1'b1; din[0] = 3'd0;
      tick();
      det[0] = 1'b0; full[0] = 8'h06;
      #1;
      chk("steer0_wr_en", 0, 32'(we0), 32'h1);
      chk("steer0_full", 0, 32'(ff0), 32'h0);
      tick();
      det[0] = 1'b1; din[0] = 3'd3;
      tick();
      det[0] = 1'b0; full[0] = 8'h00;
      #1;
      chk("bad_addr_err", 0, 32'(ae0), 32'h1);
      chk("bad_wr_en", 0, 32'(we0), 32'h0);
      chk("bad_full", 0, 32'(ff0), 32'h1);
      tick();
      det[0] = 1'b1; din[0] = 3'd1;
      tick();
      det[0] = 1'b0;
      #1;
      chk("good_addr_err", 0, 32'(ae0), 32'h0);
      chk("good_wr_en", 0, 32'(we0), 32'h2);
      tick();
      do_reset();
      empty[0] = 8'hFD;
      pulses = 0;
      for (int n = 0; n < 61; n++) begin
         #1 pulses += int'(sr0[1]);
         tick();
      end
      chk("timeout_pulses", 0, 32'(pulses), 32'd2);
      chk("timeout_sticky1", 0, 32'(st0[1]), 32'h1);
      do_reset();
      empty[0] = 8'hFD;
      pulses = 0;
      for (int n = 0; n < 29; n++) begin
         #1 pulses += int'(sr0[1]);
         tick();
      end
      rd[0] = 8'h02;
      tick();
      rd[0] = 8'h00;
      for (int n = 0; n < 29; n++) begin
         #1 pulses += int'(sr0[1]);
         tick();
      end
      empty[0] = 8'hFF;
      tick();
      empty[0] = 8'hFD;
      for (int n = 0; n < 30; n++) begin
         #1 pulses += int'(sr0[1]);
         tick();
      end
      chk("rescue_no_pulse", 0, 32'(pulses), 32'd0);
      #1 chk("rescue_late_pulse", 0, 32'(sr0[1]), 32'h1);
      tick();
      do_reset();
      empty[0] = 8'hFE;
      found = 1'b0;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (sr0[0]) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("race_found", 0, 32'(found), 32'h1);
      clr[0] = 8'h01;
      tick();
      clr[0] = 8'h00;
      #1 chk("race_set_wins", 0, 32'(st0[0]), 32'h1);
      clr[0] = 8'h01;
      tick();
      clr[0] = 8'h00;
      #1 chk("late_clear", 0, 32'(st0[0]), 32'h0);
      do_reset();
      det[0] = 1'b1; din[0] = 3'd2;
      det[1] = 1'b1; din[1] = 3'd4;
      tick();
      det[0] = 1'b0; det[1] = 1'b0;
      empty[0] = 8'hFD;
      empty[1] = 8'hEF;
      for (int n = 0; n < 20; n++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wreg[0] = 1'b1; full[0] = 8'h01;
      wreg[1] = 1'b1;
      empty[0] = 8'hFF;
      empty[1] = 8'hFF;
      #1;
      chk("midrst_addr_err", 0, 32'(ae0), 32'h0);
      chk("midrst_wr_en", 0, 32'(we0), 32'h1);
      chk("midrst_full", 0, 32'(ff0), 32'h1);
      chk("midrst_sr", 0, 32'(sr0), 32'h0);
      chk("midrst_sticky", 1, 32'(st1), 32'h0);
      chk("midrst_wr_en", 1, 32'(we1), 32'h1);
      tick();
      do_reset();
      empty[1] = 8'hEF;
      pulses = 0;
      for (int n = 0; n < 17; n++) begin
         #1 pulses += int'(sr1[4]);
         tick();
      end
      chk("p5_pulses", 1, 32'(pulses), 32'd2);
      chk("p5_sticky", 1, 32'(st1[4]), 32'h1);
      for (int n = 0; n < 4000; n++) begin
         rnd();
         tick();
      end
      rst = 1'b0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised N-channel successor to the router's 3-channel synchroniser. Sits between the router FSM/register block and the per-destination output FIFOs. Latches the destination address from the packet header and steers the single write enable to the addressed FIFO. Muxes that FIFO's full flag back to the FSM and watches each channel for unread data, issuing a one-cycle soft reset after a programmable timeout. Adds beyond the 3-channel block: invalid-address detection, a one-cycle soft-reset pulse, and sticky per-channel timeout status with software clear.

Parameters:
NUM_CH, 3, number of destination channels/FIFOs (2..8)
ADDR_W, 2, width of address field; 2**ADDR_W >= NUM_CH
TIMEOUT, 30, consecutive valid-but-unread cycles before soft reset (2..2**CNT_W)
CNT_W, 6, timeout counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
din  in  ADDR_W  destination address from header byte
detect_addr  in  1  header strobe; latch din this cycle
wr_en_reg  in  1  FIFO write request from FSM
full  in  NUM_CH  per-FIFO full flags
empty  in  NUM_CH  per-FIFO empty flags
rd_en  in  NUM_CH  per-FIFO read enables from downstream
clr_status  in  NUM_CH  clear request for timeout_sticky bits
wr_en  out  NUM_CH  one-hot (or zero) FIFO write enable
fifo_full  out  1  full flag of currently addressed FIFO
vld_out  out  NUM_CH  per-channel data valid
soft_reset  out  NUM_CH  one-cycle timeout pulse per FIFO
addr_err  out  1  latched address is >= NUM_CH
timeout_sticky  out  NUM_CH  sticky record of soft_reset events

Behaviour:
- Reset (rst=1 at clk edge): addr_q=0, addr_err=0, all cnt=0, soft_reset=0, timeout_sticky=0. Combinational outputs follow from these values: with addr_q=0 and addr_err=0, wr_en=0 unless wr_en_reg, and fifo_full=full[0].
- Address latch: when detect_addr=1, addr_q<=din and addr_err<=(din>=NUM_CH). Otherwise hold. A new header overrides the previous header; no other qualification applies.
- wr_en (combinational): if wr_en_reg=1 and addr_err=0, wr_en = 1<<addr_q; else 0. Never more than one bit set.
- fifo_full (combinational): full[addr_q] if addr_err=0; else 1, so the FSM stalls rather than writing into a nonexistent channel.
- vld_out[i] = ~empty[i] (combinational, zero latency).
- Per-channel timeout counter i (independent, NUM_CH instances):
  - if vld_out[i]=1 and rd_en[i]=0:
    - if cnt==TIMEOUT-1: soft_reset[i]<=1, cnt<=0.
    - else: cnt<=cnt+1, soft_reset[i]<=0.
  - else (empty or being read): cnt<=0, soft_reset[i]<=0. Unlike the 3-channel block, the counter does not hold while empty.
  - Timing: soft_reset[i] is high for exactly one cycle, asserted on the edge after the TIMEOUT-th consecutive unread-valid cycle. Continued neglect re-fires every TIMEOUT cycles.
- timeout_sticky[i]:
  - set when soft_reset[i] is asserted (the cycle it goes high);
  - cleared by clr_status[i]=1;
  - if set and clear occur in the same cycle, set wins;
  - otherwise holds.
- Reset mid-count or mid-packet clears all state at the next edge; no partial pulse is emitted.
- No internal FIFO state; flushing on soft_reset is done by the FIFO.

Test Plan:
- Steering: NUM_CH=3. detect_addr with din=2, then wr_en_reg=1, full=3'b100 -> wr_en=3'b100, fifo_full=1; next header din=0 -> wr_en=3'b001, fifo_full=full[0].
- Invalid address: din=3 latched -> addr_err=1, wr_en=0 with wr_en_reg=1, fifo_full=1; next header din=1 -> addr_err=0.
- Timeout: empty[1]=0, rd_en[1]=0 held -> soft_reset[1] single-cycle pulse after 30 cycles, again 30 cycles later; timeout_sticky[1]=1 and stays set.
- Read rescue: hold unread 29 cycles, pulse rd_en[1] for 1 cycle, then unread again -> no soft_reset until 30 more unread cycles; emptying the FIFO likewise restarts count.
- Sticky clear race: clr_status[0]=1 on the same cycle soft_reset[0] rises -> timeout_sticky[0]=1; clr_status[0] one cycle later -> 0.
- Reset mid-operation: rst=1 at cnt=20 with addr_q=2 -> next cycle cnt=0, addr_q=0, addr_err=0, soft_reset=0, timeout_sticky=0. Repeat with NUM_CH=5, ADDR_W=3, TIMEOUT=8 to confirm parametrisation.
